// File: rtl/alu_pipe.sv
// Pipelined, valid/ready-handshaked ALU with registered result and status flags.
// Define ALU_PIPE_MUL_EN to compile in the iterative shift-add multiplier (opcode 110).
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             busy
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NEG  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam int             MSB     = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;

  logic             accept;
  logic             idle;
  logic             load;
  logic [WIDTH-1:0] load_res;
  logic             load_carry;
  logic             load_ovf;

  // Single-cycle operations; opcode 110 yields all zeros here and is overridden by the multiplier when present.
  always_comb begin
    sum       = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (opcode)
      OP_ADD: begin
        sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        alu_res   = sum[MSB:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sum       = {1'b0, a} + {1'b0, ~b} + ONE_EXT;
        alu_res   = sum[MSB:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_NEG: begin
        sum       = {1'b0, ~b} + ONE_EXT;
        alu_res   = sum[MSB:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (b == MIN_NEG);
      end
      OP_XOR:  alu_res = a ^ b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_PASS: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  assign in_ready = rst_n && idle && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state, state_next;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      count;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The last iteration's sum is loaded straight into the output registers on the same edge.
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    mul_done   = 1'b0;
    acc_next   = acc + (mplier[0] ? mcand : '0);
    case (state)
      IDLE: begin
        if (accept && opcode == OP_MUL) begin
          mul_start  = 1'b1;
          state_next = MUL;
        end
      end
      MUL: begin
        if (count == CW'(1)) begin
          mul_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (mul_start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= CW'(WIDTH);
    end else if (state == MUL && count != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

  assign idle       = (state == IDLE);
  assign busy       = (state == MUL);
  assign load       = (accept && opcode != OP_MUL) || mul_done;
  assign load_res   = mul_done ? acc_next[MSB:0] : alu_res;
  assign load_carry = mul_done ? |acc_next[2*WIDTH-1:WIDTH] : alu_carry;
  assign load_ovf   = mul_done ? 1'b0 : alu_ovf;
`else
  assign idle       = 1'b1;
  assign busy       = 1'b0;
  assign load       = accept;
  assign load_res   = alu_res;
  assign load_carry = alu_carry;
  assign load_ovf   = alu_ovf;
`endif

  // A load always wins over a consume, so a same-edge consume+accept leaves out_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_res;
      carryout  <= load_carry;
      zero      <= (load_res == '0);
      negative  <= load_res[MSB];
      overflow  <= load_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus randomized traffic against
// an arithmetic reference model. Follows ALU_PIPE_MUL_EN the same way the design does.
module tb_alu_pipe;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic [2:0]       opcode = 3'b000;
   logic             ci = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic             carryout;
   logic             zero;
   logic             negative;
   logic             overflow;
   logic             busy;

   int checkCount = 0;
   int failCount = 0;
   bit monEnable = 1'b0;
   logic [WIDTH+3:0] expQueue[$];

   alu_pipe #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .opcode(opcode), .ci(ci),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carryout(carryout), .zero(zero),
      .negative(negative), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   // Every comparison funnels through here so the pass/fail tally stays in one place.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference behaviour from signed/unsigned integer arithmetic; returns {result, carry, ovf, zero, neg}.
   function automatic logic [WIDTH+3:0] model(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y, input logic c);
      longint m = longint'(1) << WIDTH;
      longint ua = longint'(x);
      longint ub = longint'(y);
      longint sa = x[WIDTH-1] ? ua - m : ua;
      longint sb = y[WIDTH-1] ? ub - m : ub;
      longint full = 0;
      longint ss = 0;
      logic [WIDTH-1:0] r = '0;
      logic cy = 1'b0;
      logic ov = 1'b0;
      case (op)
         3'd0: begin
            full = ua + ub + longint'(c);
            r = full[WIDTH-1:0];
            cy = (full >= m);
            ss = sa + sb + longint'(c);
            ov = (ss >= m / 2) || (ss < -(m / 2));
         end
         3'd1: begin
            full = ua - ub + m;
            r = full[WIDTH-1:0];
            cy = (ua >= ub);
            ss = sa - sb;
            ov = (ss >= m / 2) || (ss < -(m / 2));
         end
         3'd2: begin
            full = m - ub;
            r = full[WIDTH-1:0];
            cy = (ub == 0);
            ov = (-sb >= m / 2);
         end
         3'd3: r = x ^ y;
         3'd4: r = x & y;
         3'd5: r = x | y;
`ifdef ALU_PIPE_MUL_EN
         3'd6: begin
            full = ua * ub;
            r = full[WIDTH-1:0];
            cy = ((full >> WIDTH) != 0);
         end
`else
         3'd6: r = '0;
`endif
         default: r = x;
      endcase
      return {r, cy, ov, (r == '0), r[WIDTH-1]};
   endfunction

   function automatic logic [WIDTH+3:0] observed();
      return {result, carryout, overflow, zero, negative};
   endfunction

   // Offers one operation, consuming any pending result on the accept edge, then waits for its result.
   task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic c, output int lat, output int busyCycles);
      int waitCycles = 0;
      @(posedge clk); #1;
      opcode = op; a = x; b = y; ci = c;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      while (!in_ready && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      lat = 0;
      busyCycles = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) busyCycles++;
      end while (!out_valid && lat < 100);
   endtask

   // Scoreboard: an accept pushes the model's answer, a consume pops and compares.
   always @(negedge clk) begin
      if (monEnable) begin
         if (out_valid && out_ready) begin
            if (expQueue.size() == 0) checkOutput("rand_spurious", 32'd1, 32'd0);
            else checkOutput("rand_result", 32'(observed()), 32'(expQueue.pop_front()));
         end
         if (in_valid && in_ready) expQueue.push_back(model(opcode, a, b, ci));
      end
   end

   initial begin
      int lat;
      int busyCycles;
      int stale;
      bit took;

      $display("[TB] reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state", {26'd0, in_ready, out_valid, busy, zero, carryout, overflow}, 32'd0);
      checkOutput("reset_result", 32'(result), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_reset", 32'(in_ready), 32'd1);

      $display("[TB] directed arithmetic");
      applyStimulus(3'd0, 16'hFFFF, 16'h0001, 1'b0, lat, busyCycles);
      checkOutput("add_latency", 32'(lat), 32'd1);
      checkOutput("add_wrap", 32'(observed()), 32'({16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}));
      applyStimulus(3'd1, 16'h8000, 16'h0001, 1'b1, lat, busyCycles);
      checkOutput("sub_ovf", 32'(observed()), 32'({16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0}));
      applyStimulus(3'd2, 16'hABCD, 16'h0000, 1'b0, lat, busyCycles);
      checkOutput("neg_zero", 32'(observed()), 32'({16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}));
      applyStimulus(3'd2, 16'h0000, 16'h8000, 1'b0, lat, busyCycles);
      checkOutput("neg_min", 32'(observed()), 32'({16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}));

      $display("[TB] throughput");
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1;
      opcode = 3'd3; a = 16'hAAAA; b = 16'hFFFF;
      @(posedge clk); #1;
      opcode = 3'd4; a = 16'hF0F0; b = 16'h0FF0;
      @(negedge clk);
      checkOutput("tp_xor", {15'd0, out_valid, result}, {15'd0, 1'b1, 16'h5555});
      @(posedge clk); #1;
      opcode = 3'd5; a = 16'h1200; b = 16'h0034;
      @(negedge clk);
      checkOutput("tp_and", {15'd0, out_valid, result}, {15'd0, 1'b1, 16'h00F0});
      @(posedge clk); #1;
      out_ready = 1'b0;
      opcode = 3'd7; a = 16'hBEEF; b = 16'h0000;
      @(negedge clk);
      checkOutput("tp_or", {15'd0, out_valid, result}, {15'd0, 1'b1, 16'h1234});

      $display("[TB] backpressure");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("bp_hold", {14'd0, in_ready, out_valid, result}, {14'd0, 1'b0, 1'b1, 16'h1234});
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      checkOutput("bp_next", {15'd0, out_valid, result}, {15'd0, 1'b1, 16'hBEEF});

`ifdef ALU_PIPE_MUL_EN
      $display("[TB] multiplier");
      applyStimulus(3'd6, 16'h0012, 16'h0034, 1'b0, lat, busyCycles);
      checkOutput("mul_latency", 32'(lat), 32'd17);
      checkOutput("mul_busy_cycles", 32'(busyCycles), 32'd16);
      checkOutput("mul_small", 32'(observed()), 32'({16'h03A8, 1'b0, 1'b0, 1'b0, 1'b0}));
      applyStimulus(3'd6, 16'h0100, 16'h0100, 1'b0, lat, busyCycles);
      checkOutput("mul_high", 32'(observed()), 32'({16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}));

      $display("[TB] reset mid-multiply");
      @(posedge clk); #1;
      opcode = 3'd6; a = 16'h00FF; b = 16'h00FF;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      checkOutput("mul_busy_before_reset", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("mul_reset_state", {29'd0, busy, out_valid, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("mul_reset_ready", {29'd0, busy, out_valid, in_ready}, 32'd1);
      stale = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      checkOutput("mul_no_stale", 32'(stale), 32'd0);
`else
      $display("[TB] opcode 110 without multiplier");
      applyStimulus(3'd6, 16'h1234, 16'h5678, 1'b1, lat, busyCycles);
      checkOutput("mul_off_latency", 32'(lat), 32'd1);
      checkOutput("mul_off_busy", 32'(busyCycles), 32'd0);
      checkOutput("mul_off_result", 32'(observed()), 32'({16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}));
`endif

      $display("[TB] randomized traffic");
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      monEnable = 1'b1;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (!in_valid || took) begin
            in_valid = ($urandom_range(0, 3) != 0);
            opcode = 3'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            ci = 1'($urandom);
            if ($urandom_range(0, 3) == 0) a = (($urandom & 1) != 0) ? 16'h8000 : 16'h7FFF;
            if ($urandom_range(0, 3) == 0) b = (($urandom & 1) != 0) ? 16'h0000 : 16'h8000;
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100 && expQueue.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      checkOutput("rand_drain", 32'(expQueue.size()), 32'd0);
      monEnable = 1'b0;

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
